// File: rtl/symm_pkg.sv
// Shared constants, state encoding and saturation limits for the symmetric-orthogonalisation
// normalisation stage.
package symm_pkg;

  localparam int unsigned SYMM_WIDTH = 26;
  localparam int unsigned SYMM_FRAC  = 13;

  localparam int unsigned ACC_CYC  = 16;
  // The radicand is acc << FRAC with a 30-bit accumulator, padded to an even bit count.
  localparam int unsigned SQRT_CYC = (SYMM_WIDTH + 4 + SYMM_FRAC + 1) / 2;
  localparam int unsigned DIV_CYC  = SYMM_WIDTH - 1 + SYMM_FRAC;

  localparam logic signed [SYMM_WIDTH-1:0] SAT_POS = {1'b0, {(SYMM_WIDTH-1){1'b1}}};
  localparam logic signed [SYMM_WIDTH-1:0] SAT_NEG = -SAT_POS;

  typedef enum logic [1:0] {StIdle, StAcc, StSqrt, StDiv} state_e;

endpackage

// File: rtl/symm_div_seq.sv
// Restoring unsigned divider, one quotient bit per clock. done_o marks the cycle whose closing
// edge produces the final quotient bit; quot_o carries that completed quotient in the same cycle.
module symm_div_seq #(
  parameter int unsigned DvdW = 38,
  parameter int unsigned DsrW = 26
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [DvdW-1:0] dividend_i,
  input  logic [DsrW-1:0] divisor_i,
  output logic            done_o,
  output logic [DvdW-1:0] quot_o
);

  localparam int unsigned CntW = $clog2(DvdW);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DvdW-1:0] dq_q, dq_d, q_nxt;
  logic [DsrW-1:0] rem_q, rem_d, dsr_q, dsr_d, rem_nxt;
  logic [DsrW:0]   r_sh, r_sub;
  logic            ge, last;

  // Dividend bits shift out of the top of dq_q while quotient bits shift in at the bottom.
  assign r_sh    = {rem_q, dq_q[DvdW-1]};
  assign ge      = r_sh >= {1'b0, dsr_q};
  assign r_sub   = r_sh - {1'b0, dsr_q};
  assign rem_nxt = ge ? DsrW'(r_sub) : DsrW'(r_sh);
  assign q_nxt   = {dq_q[DvdW-2:0], ge};
  assign last    = (cnt_q == CntW'(DvdW - 1));

  assign done_o = busy_q & last;
  assign quot_o = q_nxt;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    dq_d   = dq_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      dq_d   = dividend_i;
      rem_d  = '0;
      dsr_d  = divisor_i;
    end else if (busy_q) begin
      dq_d  = q_nxt;
      rem_d = rem_nxt;
      cnt_d = cnt_q + CntW'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dq_q   <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dq_q   <= dq_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
    end
  end

endmodule

// File: rtl/symm_norm.sv
// Normalises a 4x4 Q13 matrix by its Frobenius norm: accumulate squares, bit-serial square root,
// then 16 sequential divisions through one shared divider.
module symm_norm
  import symm_pkg::*;
#(
  parameter int unsigned WIDTH = SYMM_WIDTH,
  parameter int unsigned FRAC  = SYMM_FRAC
) (
  input  logic                    clk_norm,
  input  logic                    rstn_norm,
  input  logic                    en_norm,
  input  logic signed [WIDTH-1:0] w11, w12, w13, w14, w21, w22, w23, w24,
  input  logic signed [WIDTH-1:0] w31, w32, w33, w34, w41, w42, w43, w44,
  input  logic signed [WIDTH-1:0] w11_2, w12_2, w13_2, w14_2, w21_2, w22_2, w23_2, w24_2,
  input  logic signed [WIDTH-1:0] w31_2, w32_2, w33_2, w34_2, w41_2, w42_2, w43_2, w44_2,
  output logic signed [WIDTH-1:0] n11, n12, n13, n14, n21, n22, n23, n24,
  output logic signed [WIDTH-1:0] n31, n32, n33, n34, n41, n42, n43, n44,
  output logic        [WIDTH-1:0] norm,
  output logic                    busy,
  output logic                    done,
  output logic                    err_zero
);

  localparam int unsigned NumEl = ACC_CYC;
  localparam int unsigned AccW  = WIDTH + 4;
  localparam int unsigned RootW = SQRT_CYC;
  localparam int unsigned RadW  = 2 * SQRT_CYC;
  localparam int unsigned RemW  = RootW + 2;
  localparam int unsigned DvdW  = DIV_CYC;
  localparam int unsigned CntW  = $clog2(SQRT_CYC);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] w_in [NumEl];
  logic signed [WIDTH-1:0] w2_in[NumEl];
  logic signed [WIDTH-1:0] w_q  [NumEl];
  logic signed [WIDTH-1:0] w_d  [NumEl];
  logic signed [WIDTH-1:0] w2_q [NumEl];
  logic signed [WIDTH-1:0] w2_d [NumEl];
  logic signed [WIDTH-1:0] n_q  [NumEl];
  logic signed [WIDTH-1:0] n_d  [NumEl];

  logic [AccW-1:0]  acc_q, acc_d, acc_nxt;
  logic [RadW-1:0]  rad_q, rad_d;
  logic [RemW-1:0]  rem_q, rem_d;
  logic [RemW+1:0]  rem_sh, trial, rem_nxt;
  logic [RootW-1:0] root_q, root_d, root_nxt;
  logic             sqrt_ge;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d, div_sel;
  logic [WIDTH-1:0] norm_q, norm_d;
  logic             err_q, err_d, done_q, done_d;

  logic signed [WIDTH-1:0] w2_cur, w_sel, n_val;
  logic [WIDTH-1:0]        w_abs, q_mag, div_dsr;
  logic [DvdW-1:0]         div_dvd, div_quot;
  logic                    div_start, div_done;

  assign w_in  = '{w11, w12, w13, w14, w21, w22, w23, w24,
                   w31, w32, w33, w34, w41, w42, w43, w44};
  assign w2_in = '{w11_2, w12_2, w13_2, w14_2, w21_2, w22_2, w23_2, w24_2,
                   w31_2, w32_2, w33_2, w34_2, w41_2, w42_2, w43_2, w44_2};

  // Negative squares are clamped to zero before accumulation.
  assign w2_cur  = w2_q[cnt_q[3:0]];
  assign acc_nxt = acc_q + (w2_cur[WIDTH-1] ? AccW'(0) : AccW'($unsigned(w2_cur)));

  // Restoring square root: bring down two radicand bits, try subtracting (4*root + 1).
  assign rem_sh   = {rem_q, rad_q[RadW-1 -: 2]};
  assign trial    = {2'b00, root_q, 2'b01};
  assign sqrt_ge  = rem_sh >= trial;
  assign rem_nxt  = sqrt_ge ? (rem_sh - trial) : rem_sh;
  assign root_nxt = {root_q[RootW-2:0], sqrt_ge};

  // Magnitude division; the element's sign is reapplied after saturation.
  assign w_sel   = w_q[div_sel];
  assign w_abs   = w_sel[WIDTH-1] ? $unsigned(-w_sel) : $unsigned(w_sel);
  assign div_dvd = DvdW'({w_abs, {FRAC{1'b0}}});
  assign div_dsr = (state_q == StSqrt) ? WIDTH'(root_nxt) : norm_q;
  assign q_mag   = (div_quot > DvdW'(SAT_POS)) ? WIDTH'(SAT_POS) : WIDTH'(div_quot);
  assign n_val   = w_q[idx_q][WIDTH-1] ? -$signed(q_mag) : $signed(q_mag);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    w2_d      = w2_q;
    n_d       = n_q;
    acc_d     = acc_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    norm_d    = norm_q;
    err_d     = err_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    div_sel   = idx_q + 4'd1;
    unique case (state_q)
      StIdle: begin
        if (en_norm) begin
          w_d     = w_in;
          w2_d    = w2_in;
          acc_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ACC_CYC - 1)) begin
          cnt_d   = '0;
          rad_d   = RadW'({acc_nxt, {FRAC{1'b0}}});
          rem_d   = '0;
          root_d  = '0;
          state_d = StSqrt;
        end
      end
      StSqrt: begin
        rad_d  = rad_q << 2;
        rem_d  = RemW'(rem_nxt);
        root_d = root_nxt;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(SQRT_CYC - 1)) begin
          cnt_d  = '0;
          norm_d = WIDTH'(root_nxt);
          if (root_nxt == '0) begin
            for (int i = 0; i < NumEl; i++) begin
              n_d[i] = '0;
            end
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            div_start = 1'b1;
            div_sel   = '0;
            state_d   = StDiv;
          end
        end
      end
      StDiv: begin
        if (div_done) begin
          n_d[idx_q] = n_val;
          if (idx_q == 4'(NumEl - 1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d     = idx_q + 4'd1;
            div_start = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_norm or negedge rstn_norm) begin
    if (!rstn_norm) begin
      state_q <= StIdle;
      for (int i = 0; i < NumEl; i++) begin
        w_q[i]  <= '0;
        w2_q[i] <= '0;
        n_q[i]  <= '0;
      end
      acc_q  <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      norm_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      w2_q    <= w2_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      norm_q  <= norm_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  symm_div_seq #(
    .DvdW(DvdW),
    .DsrW(WIDTH)
  ) u_div (
    .clk_i     (clk_norm),
    .rst_ni    (rstn_norm),
    .start_i   (div_start),
    .dividend_i(div_dvd),
    .divisor_i (div_dsr),
    .done_o    (div_done),
    .quot_o    (div_quot)
  );

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign err_zero = err_q;
  assign norm     = norm_q;

  assign n11 = n_q[0];
  assign n12 = n_q[1];
  assign n13 = n_q[2];
  assign n14 = n_q[3];
  assign n21 = n_q[4];
  assign n22 = n_q[5];
  assign n23 = n_q[6];
  assign n24 = n_q[7];
  assign n31 = n_q[8];
  assign n32 = n_q[9];
  assign n33 = n_q[10];
  assign n34 = n_q[11];
  assign n41 = n_q[12];
  assign n42 = n_q[13];
  assign n43 = n_q[14];
  assign n44 = n_q[15];

endmodule

// File: tb/tb_symm_norm.sv
// Self-checking bench for symm_norm: directed and random matrices against an arithmetic model
// of norm = floor(sqrt(sum(max(w2,0)) << 13)) and n = sat(trunc((|w| << 13) / norm)) * sign(w).
module tb_symm_norm;

  localparam int LatFull = 646;
  localparam int LatZero = 38;
  localparam longint SatMax = 33554431;

  logic clk_norm = 1'b0;
  logic rstn_norm;
  logic en_norm;
  logic signed [25:0] tw [16];
  logic signed [25:0] tw2[16];
  logic signed [25:0] dn [16];
  logic [25:0] dnorm;
  logic dbusy, ddone, derr;

  logic signed [25:0] exp_n [16];
  logic signed [25:0] last_n[16];
  logic [25:0] exp_norm, last_norm;
  logic exp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_norm = ~clk_norm;

  symm_norm dut (
    .clk_norm (clk_norm),
    .rstn_norm(rstn_norm),
    .en_norm  (en_norm),
    .w11(tw[0]),  .w12(tw[1]),  .w13(tw[2]),  .w14(tw[3]),
    .w21(tw[4]),  .w22(tw[5]),  .w23(tw[6]),  .w24(tw[7]),
    .w31(tw[8]),  .w32(tw[9]),  .w33(tw[10]), .w34(tw[11]),
    .w41(tw[12]), .w42(tw[13]), .w43(tw[14]), .w44(tw[15]),
    .w11_2(tw2[0]),  .w12_2(tw2[1]),  .w13_2(tw2[2]),  .w14_2(tw2[3]),
    .w21_2(tw2[4]),  .w22_2(tw2[5]),  .w23_2(tw2[6]),  .w24_2(tw2[7]),
    .w31_2(tw2[8]),  .w32_2(tw2[9]),  .w33_2(tw2[10]), .w34_2(tw2[11]),
    .w41_2(tw2[12]), .w42_2(tw2[13]), .w43_2(tw2[14]), .w44_2(tw2[15]),
    .n11(dn[0]),  .n12(dn[1]),  .n13(dn[2]),  .n14(dn[3]),
    .n21(dn[4]),  .n22(dn[5]),  .n23(dn[6]),  .n24(dn[7]),
    .n31(dn[8]),  .n32(dn[9]),  .n33(dn[10]), .n34(dn[11]),
    .n41(dn[12]), .n42(dn[13]), .n43(dn[14]), .n44(dn[15]),
    .norm    (dnorm),
    .busy    (dbusy),
    .done    (ddone),
    .err_zero(derr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned r = 0;
    longint unsigned t;
    for (int b = 23; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  task automatic calc_model();
    longint unsigned acc = 0;
    longint unsigned r;
    longint mag, q;
    for (int i = 0; i < 16; i++) begin
      if (tw2[i] > 0) acc += longint'(tw2[i]);
    end
    r = isqrt(acc << 13);
    exp_norm = 26'(r);
    exp_err  = (r == 0);
    for (int i = 0; i < 16; i++) begin
      if (r == 0) begin
        exp_n[i] = '0;
      end else begin
        mag = (tw[i] < 0) ? -longint'(tw[i]) : longint'(tw[i]);
        q   = (mag << 13) / longint'(r);
        if (q > SatMax) q = SatMax;
        exp_n[i] = 26'((tw[i] < 0) ? -q : q);
      end
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, " norm"}, dnorm, exp_norm);
    chk({tag, " err_zero"}, derr, exp_err);
    chk({tag, " busy"}, dbusy, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s n[%0d]", tag, i), dn[i], exp_n[i]);
    end
  endtask

  task automatic remember();
    last_n    = exp_n;
    last_norm = exp_norm;
  endtask

  task automatic scramble();
    for (int i = 0; i < 16; i++) begin
      tw[i]  = 26'($urandom);
      tw2[i] = 26'($urandom);
    end
  endtask

  task automatic set_all(input int w, input int w2);
    for (int i = 0; i < 16; i++) begin
      tw[i]  = 26'(w);
      tw2[i] = 26'(w2);
    end
  endtask

  task automatic set_identity();
    set_all(0, 0);
    for (int i = 0; i < 4; i++) begin
      tw[i*5]  = 26'sd8192;
      tw2[i*5] = 26'sd8192;
    end
  endtask

  task automatic set_rand_consistent();
    for (int i = 0; i < 16; i++) begin
      tw[i]  = 26'(int'($urandom_range(0, 524287)) - 262144);
      tw2[i] = 26'((longint'(tw[i]) * longint'(tw[i])) >>> 13);
    end
  endtask

  task automatic set_rand_sat();
    for (int i = 0; i < 16; i++) begin
      tw[i]  = 26'(int'($urandom_range(0, 67108862)) - 33554431);
      tw2[i] = 26'(int'($urandom_range(0, 20)) - 4);
    end
  endtask

  // One full operation: start, optionally disturb inputs after acceptance, wait for done.
  task automatic run_op(input string tag, input bit scr);
    int cyc = 0;
    bit got = 1'b0;
    int lat;
    calc_model();
    lat = exp_err ? LatZero : LatFull;
    @(negedge clk_norm);
    en_norm = 1'b1;
    @(posedge clk_norm);
    #1;
    en_norm = 1'b0;
    chk({tag, " busy after start"}, dbusy, 1'b1);
    chk({tag, " err cleared"}, derr, 1'b0);
    chk({tag, " n11 held"}, dn[0], last_n[0]);
    chk({tag, " n44 held"}, dn[15], last_n[15]);
    chk({tag, " norm held"}, dnorm, last_norm);
    if (scr) scramble();
    while (!got && cyc < 1000) begin
      @(posedge clk_norm);
      #1;
      cyc++;
      got = ddone;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk_outs(tag);
    @(posedge clk_norm);
    #1;
    chk({tag, " done one cycle"}, ddone, 1'b0);
    remember();
  endtask

  initial begin
    int pulses;
    int first_at;
    int second_at;
    rstn_norm = 1'b1;
    en_norm   = 1'b0;
    set_all(0, 0);
    #2 rstn_norm = 1'b0;
    #1;
    exp_norm = '0;
    exp_err  = 1'b0;
    for (int i = 0; i < 16; i++) exp_n[i] = '0;
    chk("reset done", ddone, 1'b0);
    chk_outs("reset");
    remember();
    repeat (2) @(posedge clk_norm);
    @(negedge clk_norm);
    rstn_norm = 1'b1;

    set_identity();
    run_op("identity", 1'b1);
    chk("identity n11 value", dn[0], 26'sd4096);
    chk("identity norm value", dnorm, 26'd16384);

    set_all(4096, 2048);
    run_op("uniform", 1'b1);
    chk("uniform n23 value", dn[6], 26'sd2048);

    set_all(0, 0);
    tw[0]  = -26'sd8192;
    tw2[0] = 26'sd8192;
    run_op("neg_single", 1'b1);
    chk("neg_single n11 value", dn[0], -26'sd8192);

    set_all(0, 0);
    run_op("zero", 1'b1);
    chk("zero err value", derr, 1'b1);

    // en_norm held high: back-to-back runs, each restarting only from idle.
    set_identity();
    calc_model();
    @(negedge clk_norm);
    en_norm   = 1'b1;
    pulses    = 0;
    first_at  = -1;
    second_at = -1;
    @(posedge clk_norm);
    for (int c = 1; c <= 2 * LatFull + 1; c++) begin
      @(posedge clk_norm);
      #1;
      if (ddone) begin
        pulses++;
        if (first_at < 0) first_at = c;
        else if (second_at < 0) second_at = c;
      end
    end
    en_norm = 1'b0;
    chk("held_en pulses", 64'(pulses), 64'd2);
    chk("held_en first", 64'(first_at), 64'(LatFull));
    chk("held_en second", 64'(second_at), 64'(2 * LatFull + 1));
    chk_outs("held_en");
    remember();
    repeat (2) @(posedge clk_norm);

    for (int k = 0; k < 3; k++) begin
      set_rand_consistent();
      run_op($sformatf("rand%0d", k), 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      set_rand_sat();
      run_op($sformatf("sat%0d", k), 1'b1);
    end

    // Asynchronous reset in the middle of the division phase.
    set_rand_consistent();
    @(negedge clk_norm);
    en_norm = 1'b1;
    @(posedge clk_norm);
    #1;
    en_norm = 1'b0;
    repeat (200) begin
      @(posedge clk_norm);
      #1;
    end
    #2 rstn_norm = 1'b0;
    #1;
    exp_norm = '0;
    exp_err  = 1'b0;
    for (int i = 0; i < 16; i++) exp_n[i] = '0;
    chk("midrst done", ddone, 1'b0);
    chk_outs("midrst");
    remember();
    @(negedge clk_norm);
    rstn_norm = 1'b1;
    set_rand_consistent();
    run_op("restart", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/symm_norm.md
Name: symm_norm

Overview:
- Consumes the 4x4 Q13 matrix W and its element-wise squares W_2 produced by the symmetric-orthogonalisation multiply stage.
- Reduces W_2 to the squared Frobenius norm, takes a bit-serial square root, then divides each element of W by that norm using one shared sequential divider.
- Outputs the normalised matrix N = W / ||W||_F, which is the entry point of the iterative symmetric-orthogonalisation loop.

Parameters:
- WIDTH, 26, signed element width (all matrix ports).
- FRAC, 13, fractional bits (Q13); radicand and dividend are pre-shifted by FRAC.

Ports:
- clk_norm  input  1  single clock, rising edge.
- rstn_norm  input  1  asynchronous, active-low reset.
- en_norm  input  1  start request; sampled only in IDLE.
- w11..w44  input  16 x WIDTH signed  matrix W, Q13.
- w11_2..w44_2  input  16 x WIDTH signed  squared elements of W, Q13; expected to be non-negative.
- n11..n44  output  16 x WIDTH signed reg  normalised matrix, Q13.
- norm  output  WIDTH unsigned reg  ||W||_F, Q13.
- busy  output  1  high in ACC, SQRT and DIV.
- done  output  1  one-cycle completion pulse.
- err_zero  output  1  norm was 0; held until the next accepted start.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All n**, norm, busy, done, err_zero, counters and accumulators clear to 0. An in-flight operation is discarded.
- States: IDLE -> ACC -> SQRT -> DIV -> IDLE. A zero norm takes SQRT -> IDLE directly.
- Edge numbering: E0 is the edge that accepts en_norm=1 in IDLE.
- IDLE, accept (E0):
  - Latch all 32 inputs.
  - Clear the accumulator; set busy=1; clear err_zero.
  - en_norm while busy is ignored; no queuing.
- ACC (E1..E16):
  - Add one latched w_2 per edge, row-major order 11,12,...,44.
  - Any negative w_2 is clamped to 0 before adding.
  - Accumulator is 30-bit unsigned; overflow is impossible.
- SQRT (E17..E38):
  - Restoring bit-serial square root of radicand = acc << FRAC (43 bits).
  - One result bit per edge, MSB first, 22 iterations.
  - Result is truncated (floor).
  - norm is written at E38, zero-extended to WIDTH.
- Zero norm: if the root is 0 at E38, write all n**=0 and set err_zero=1. done pulses high in the cycle after E38, busy falls at E38, state returns to IDLE.
- DIV (E39..E646):
  - Elements are processed row-major, 38 edges each, through symm_div_seq.
  - Dividend = |w| << FRAC (38-bit); divisor = norm; 1 quotient bit per edge.
  - Quotient truncates toward zero; the sign of w is re-applied after division.
  - Result saturates to +/-(2^(WIDTH-1)-1).
  - Each n** updates on the edge its quotient completes; other outputs hold.
- Completion: at E646, busy=0 and done=1 for exactly one cycle (the cycle after E646). Total latency is 646 edges after acceptance.
- Outputs hold their last values in IDLE until the next completion; a new start does not clear n**.
- Inputs may change after E0 without effect, because the latched copy is used.

Decomposition:
- Package symm_pkg holds:
  - WIDTH/FRAC defaults.
  - FSM state enum (IDLE, ACC, SQRT, DIV).
  - Constants ACC_CYC=16, SQRT_CYC=22, DIV_CYC=38.
  - Saturation limits.
- Sub-module symm_div_seq (start/done, restoring unsigned divider, 38-bit dividend, 26-bit divisor), instantiated once and shared across all 16 elements.
- The square-root unit stays inline in symm_norm.

Test Plan:
- Identity (w_ii=8192, w_ii_2=8192, rest 0) -> norm=16384; n11=n22=n33=n44=4096, rest 0; done exactly at E646+1; err_zero=0.
- All elements 4096, all w_2=2048 -> acc=32768; norm=16384; all n**=2048.
- Only w11=-8192, w11_2=8192 -> norm=8192; n11=-8192, rest 0 (sign and truncation path).
- All-zero W -> err_zero=1; done in the cycle after E38; all n**=0; norm=0.
- en_norm held high continuously during the identity case -> exactly one done pulse per 647-cycle run; the second run starts only from IDLE.
- rstn_norm low mid-DIV (around E200) -> all outputs 0 immediately (asynchronous); a restart after release yields correct results with no stale partial quotients.
